rv_fwd_delay_line: RTL and testbench

//  Parametrised ready/valid delay line: DEPTH cascaded forward-buffer stages, DATA_WIDTH wide.

---
 rtl/rv_fwd_delay_line_pkg.sv | 19 +
 rtl/rv_fwd_stage.sv | 54 +++++
 rtl/rv_fwd_delay_line.sv | 98 +++++++++
 tb/tb_rv_fwd_delay_line.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fwd_delay_line_pkg.sv
// Shared defaults and helpers for the ready/valid forward delay line.
package rv_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH      = 5;

  // Smallest number of bits able to index 'value' distinct states (ceil(log2(value))).
  function automatic int unsigned rv_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rv_fwd_stage.sv
// One forward-buffer stage: registered valid and payload, combinational
// ready pass-through (no skid), synchronous clear of the valid bit.
module rv_fwd_stage
  import rv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock_port,
  input  logic                  reset_port,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  logic                  v_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  load;

  // Stage can take a word when empty or when its content leaves this cycle.
  always_comb begin
    in_ready = ~v_q | out_ready;
    load     = in_valid & in_ready;
  end

  // Valid bit: clear wins, then load, then drain, else hold.
  always_ff @(posedge clock_port or negedge reset_port) begin
    if (!reset_port) begin
      v_q <= 1'b0;
    end else if (clear) begin
      v_q <= 1'b0;
    end else if (load) begin
      v_q <= 1'b1;
    end else if (out_ready && v_q) begin
      v_q <= 1'b0;
    end
  end

  // Payload only changes on a load; a clear leaves it untouched.
  always_ff @(posedge clock_port or negedge reset_port) begin
    if (!reset_port) begin
      d_q <= '0;
    end else if (load && !clear) begin
      d_q <= in_data;
    end
  end

  assign out_valid = v_q;
  assign out_data  = d_q;

endmodule

// File: rtl/rv_fwd_delay_line.sv
// DEPTH-stage ready/valid delay line with flush, occupancy counter and
// full/empty flags. Full throughput; latency DEPTH-1 edges after acceptance.
module rv_fwd_delay_line
  import rv_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int unsigned DEPTH      = DEFAULT_DEPTH,
  localparam int unsigned CNT_W      = rv_clog2(DEPTH + 1)
) (
  input  logic                  clock_port,
  input  logic                  reset_port,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] input_port_data,
  input  logic                  input_port_valid,
  output logic                  input_port_ready,
  output logic [DATA_WIDTH-1:0] output_port_data,
  output logic                  output_port_valid,
  input  logic                  output_port_ready,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  empty,
  output logic                  full
);

  logic                  head_ready;
  logic                  tail_valid;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  in_xfer;
  logic                  out_xfer;
  logic [CNT_W-1:0]      occ_q;

  // Per-stage nets live inside the generate scope so the ready chain is a
  // sequence of distinct signals rather than bits of one self-dependent vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic                  v_in;
    logic                  rdy_in;
    logic                  rdy_out;
    logic                  v_o;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_o;

    if (k == 0) begin : g_head
      assign v_in       = input_port_valid;
      assign d_in       = input_port_data;
      assign head_ready = rdy_in;
    end else begin : g_link
      assign v_in = g_stage[k-1].v_o;
      assign d_in = g_stage[k-1].d_o;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign rdy_out    = output_port_ready;
      assign tail_valid = v_o;
      assign tail_data  = d_o;
    end else begin : g_fwd
      assign rdy_out = g_stage[k+1].rdy_in;
    end

    rv_fwd_stage #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
      .clock_port (clock_port),
      .reset_port (reset_port),
      .clear      (clear),
      .in_valid   (v_in),
      .in_data    (d_in),
      .in_ready   (rdy_in),
      .out_valid  (v_o),
      .out_data   (d_o),
      .out_ready  (rdy_out)
    );
  end

  // Clear blocks both handshakes in its cycle; flags decode the counter.
  always_comb begin
    input_port_ready  = head_ready & ~clear;
    output_port_valid = tail_valid & ~clear;
    output_port_data  = tail_data;
    in_xfer           = input_port_valid & input_port_ready;
    out_xfer          = output_port_valid & output_port_ready;
    occupancy         = occ_q;
    empty             = (occ_q == '0);
    full              = (occ_q == CNT_W'(DEPTH));
  end

  // Occupancy tracks transfers; simultaneous in/out leaves it unchanged.
  always_ff @(posedge clock_port or negedge reset_port) begin
    if (!reset_port) begin
      occ_q <= '0;
    end else if (clear) begin
      occ_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ_q <= occ_q + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_q <= occ_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv_fwd_delay_line.sv
// Directed bench for rv_fwd_delay_line: default 5x8 instance plus 1x1 and 8x32 instances.
module tb_rv_fwd_delay_line;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Default instance (DEPTH=5, DATA_WIDTH=8)
  logic       clear = 1'b0;
  logic       ivalid = 1'b0, iready, ovalid, oready = 1'b0, empty, full;
  logic [7:0] idata = '0, odata;
  logic [2:0] occ;

  // DEPTH=1, DATA_WIDTH=1
  logic       p1_clr = 1'b0, p1_iv = 1'b0, p1_ir, p1_ov, p1_or = 1'b0, p1_empty, p1_full;
  logic [0:0] p1_id = '0, p1_od, p1_occ;

  // DEPTH=8, DATA_WIDTH=32
  logic        p8_clr = 1'b0, p8_iv = 1'b0, p8_ir, p8_ov, p8_or = 1'b0, p8_empty, p8_full;
  logic [31:0] p8_id = '0, p8_od;
  logic [3:0]  p8_occ;

  rv_fwd_delay_line #(.DATA_WIDTH(8), .DEPTH(5)) dut (
    .clock_port(clk), .reset_port(rst_n), .clear(clear),
    .input_port_data(idata), .input_port_valid(ivalid), .input_port_ready(iready),
    .output_port_data(odata), .output_port_valid(ovalid), .output_port_ready(oready),
    .occupancy(occ), .empty(empty), .full(full));

  rv_fwd_delay_line #(.DATA_WIDTH(1), .DEPTH(1)) dut_p1 (
    .clock_port(clk), .reset_port(rst_n), .clear(p1_clr),
    .input_port_data(p1_id), .input_port_valid(p1_iv), .input_port_ready(p1_ir),
    .output_port_data(p1_od), .output_port_valid(p1_ov), .output_port_ready(p1_or),
    .occupancy(p1_occ), .empty(p1_empty), .full(p1_full));

  rv_fwd_delay_line #(.DATA_WIDTH(32), .DEPTH(8)) dut_p8 (
    .clock_port(clk), .reset_port(rst_n), .clear(p8_clr),
    .input_port_data(p8_id), .input_port_valid(p8_iv), .input_port_ready(p8_ir),
    .output_port_data(p8_od), .output_port_valid(p8_ov), .output_port_ready(p8_or),
    .occupancy(p8_occ), .empty(p8_empty), .full(p8_full));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    ivalid = v;
    idata  = d;
    oready = r;
  endtask

  // Structural invariants sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_popcount",
          32'(int'(dut.g_stage[0].v_o) + int'(dut.g_stage[1].v_o) + int'(dut.g_stage[2].v_o)
            + int'(dut.g_stage[3].v_o) + int'(dut.g_stage[4].v_o)),
          32'(occ));
      chk("inv_full_stall", 32'(full && !oready && iready), 32'd0);
      chk("inv_p1_full_stall", 32'(p1_full && !p1_or && p1_ir), 32'd0);
      chk("inv_p8_full_stall", 32'(p8_full && !p8_or && p8_ir), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state
    #1;
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_odata", 32'(odata), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_p1_empty", 32'(p1_empty), 32'd1);
    chk("rst_p8_occ", 32'(p8_occ), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- 1: streaming 0x01..0x20
    drive(1'b1, 8'h01, 1'b1);
    #1 chk("t1_iready", 32'(iready), 32'd1);
    for (int k = 1; k <= 38; k++) begin
      int acc, em;
      logic ev;
      tick();
      ev  = (k >= 5) && (k <= 36);
      acc = (k < 32) ? k : 32;
      em  = (k < 5) ? 0 : (((k < 37) ? k : 37) - 5);
      chk("t1_ovalid", 32'(ovalid), 32'(ev));
      if (ev) chk("t1_odata", 32'(odata), 32'(k - 4));
      chk("t1_occ", 32'(occ), 32'(acc - em));
      if (k < 32) drive(1'b1, 8'(k + 1), 1'b1);
      else        drive(1'b0, 8'h00, 1'b1);
    end
    chk("t1_empty_end", 32'(empty), 32'd1);

    // ---- 2: backpressure fill
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(8'hA0 + k), 1'b0);
      #1 chk("t2_iready_fill", 32'(iready), 32'd1);
      tick();
      chk("t2_occ_fill", 32'(occ), 32'(k + 1));
    end
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_ovalid", 32'(ovalid), 32'd1);
    chk("t2_odata_head", 32'(odata), 32'hA0);
    drive(1'b1, 8'hA5, 1'b0);
    #1 chk("t2_iready_stall", 32'(iready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t2_occ_stall", 32'(occ), 32'd5);
      chk("t2_odata_stall", 32'(odata), 32'hA0);
    end
    drive(1'b1, 8'hA5, 1'b1);
    #1 chk("t2_iready_release", 32'(iready), 32'd1);
    tick();
    chk("t2_odata_d1", 32'(odata), 32'hA1);
    chk("t2_occ_d1", 32'(occ), 32'd5);
    drive(1'b1, 8'hA6, 1'b1);
    #1 chk("t2_iready_d2", 32'(iready), 32'd1);
    tick();
    chk("t2_odata_d2", 32'(odata), 32'hA2);
    chk("t2_occ_d2", 32'(occ), 32'd5);
    drive(1'b0, 8'h00, 1'b1);
    for (int k = 3; k <= 7; k++) begin
      tick();
      if (k <= 6) begin
        chk("t2_ovalid_drain", 32'(ovalid), 32'd1);
        chk("t2_odata_drain", 32'(odata), 32'(8'hA0 + k));
        chk("t2_occ_drain", 32'(occ), 32'(7 - k));
      end else begin
        chk("t2_ovalid_end", 32'(ovalid), 32'd0);
        chk("t2_empty_end", 32'(empty), 32'd1);
      end
    end

    // ---- 3: full pass-through
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(8'h10 + k), 1'b0);
      tick();
    end
    chk("t3_full", 32'(full), 32'd1);
    drive(1'b1, 8'h55, 1'b1);
    #1 chk("t3_iready_full", 32'(iready), 32'd1);
    tick();
    chk("t3_occ_pass", 32'(occ), 32'd5);
    chk("t3_odata_pass", 32'(odata), 32'h11);
    drive(1'b0, 8'h00, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t3_ovalid", 32'(ovalid), 32'd1);
      chk("t3_odata", 32'(odata), (k < 4) ? 32'(8'h11 + k) : 32'h55);
      chk("t3_occ", 32'(occ), 32'(5 - k));
    end
    tick();
    chk("t3_empty", 32'(empty), 32'd1);

    // ---- 4: clear
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'h31 + k), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    chk("t4_held_ovalid", 32'(ovalid), 32'd1);
    chk("t4_held_odata", 32'(odata), 32'h31);
    chk("t4_held_occ", 32'(occ), 32'd3);
    clear = 1'b1;
    drive(1'b1, 8'h77, 1'b1);
    #1;
    chk("t4_clr_iready", 32'(iready), 32'd0);
    chk("t4_clr_ovalid", 32'(ovalid), 32'd0);
    tick();
    clear = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    #1;
    chk("t4_post_empty", 32'(empty), 32'd1);
    chk("t4_post_occ", 32'(occ), 32'd0);
    chk("t4_post_ovalid", 32'(ovalid), 32'd0);
    chk("t4_post_data_held", 32'(odata), 32'h31);
    drive(1'b1, 8'h41, 1'b1);
    #1 chk("t4_iready_after", 32'(iready), 32'd1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t4_lat_ovalid", 32'(ovalid), 32'(k == 4));
      if (k == 4) chk("t4_lat_odata", 32'(odata), 32'h41);
    end
    tick();
    chk("t4_empty_end", 32'(empty), 32'd1);

    // ---- 5: asynchronous reset mid-stream
    drive(1'b1, 8'h61, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      drive(1'b1, 8'(8'h61 + k), 1'b1);
    end
    chk("t5_stream_ovalid", 32'(ovalid), 32'd1);
    chk("t5_stream_odata", 32'(odata), 32'h63);
    drive(1'b0, 8'h00, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ovalid", 32'(ovalid), 32'd0);
    chk("t5_rst_odata", 32'(odata), 32'd0);
    chk("t5_rst_empty", 32'(empty), 32'd1);
    chk("t5_rst_full", 32'(full), 32'd0);
    chk("t5_rst_occ", 32'(occ), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    drive(1'b1, 8'h71, 1'b1);
    #1 chk("t5_iready", 32'(iready), 32'd1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t5_lat_ovalid", 32'(ovalid), 32'(k == 4));
      if (k == 4) chk("t5_lat_odata", 32'(odata), 32'h71);
    end
    tick();
    chk("t5_empty_end", 32'(empty), 32'd1);

    // ---- 6a: DEPTH=1, DATA_WIDTH=1
    p1_or = 1'b1; p1_iv = 1'b1; p1_id = 1'b1;
    #1 chk("p1_iready", 32'(p1_ir), 32'd1);
    tick();
    chk("p1_ovalid_lat", 32'(p1_ov), 32'd1);
    chk("p1_odata_0", 32'(p1_od), 32'd1);
    chk("p1_occ_0", 32'(p1_occ), 32'd1);
    p1_id = 1'b0;
    tick();
    chk("p1_odata_1", 32'(p1_od), 32'd0);
    chk("p1_occ_1", 32'(p1_occ), 32'd1);
    p1_id = 1'b1;
    tick();
    chk("p1_odata_2", 32'(p1_od), 32'd1);
    p1_iv = 1'b0;
    tick();
    chk("p1_ovalid_end", 32'(p1_ov), 32'd0);
    chk("p1_empty_end", 32'(p1_empty), 32'd1);
    p1_or = 1'b0; p1_iv = 1'b1; p1_id = 1'b1;
    tick();
    chk("p1_full", 32'(p1_full), 32'd1);
    chk("p1_occ_full", 32'(p1_occ), 32'd1);
    p1_id = 1'b0;
    #1 chk("p1_iready_stall", 32'(p1_ir), 32'd0);
    tick();
    chk("p1_odata_stall", 32'(p1_od), 32'd1);
    chk("p1_occ_stall", 32'(p1_occ), 32'd1);
    p1_or = 1'b1;
    #1 chk("p1_iready_pass", 32'(p1_ir), 32'd1);
    tick();
    chk("p1_odata_pass", 32'(p1_od), 32'd0);
    chk("p1_full_pass", 32'(p1_full), 32'd1);
    p1_iv = 1'b0;
    tick();
    chk("p1_empty_drain", 32'(p1_empty), 32'd1);

    // ---- 6b: DEPTH=8, DATA_WIDTH=32
    p8_or = 1'b1; p8_iv = 1'b1; p8_id = 32'hDEAD_0001;
    tick();
    p8_iv = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk("p8_lat_ovalid", 32'(p8_ov), 32'(k == 8));
      if (k == 8) chk("p8_lat_odata", p8_od, 32'hDEAD_0001);
    end
    p8_or = 1'b0;
    for (int k = 0; k < 8; k++) begin
      p8_iv = 1'b1;
      p8_id = 32'hC000_0000 + 32'(k);
      #1 chk("p8_iready_fill", 32'(p8_ir), 32'd1);
      tick();
      chk("p8_occ_fill", 32'(p8_occ), 32'(k + 1));
    end
    chk("p8_full", 32'(p8_full), 32'd1);
    chk("p8_head", p8_od, 32'hC000_0000);
    p8_id = 32'hC000_0008;
    #1 chk("p8_iready_stall", 32'(p8_ir), 32'd0);
    tick();
    chk("p8_occ_nowrap", 32'(p8_occ), 32'd8);
    p8_iv = 1'b0; p8_or = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("p8_drain_odata", p8_od, 32'hC000_0000 + 32'(k));
      tick();
    end
    chk("p8_empty_end", 32'(p8_empty), 32'd1);
    chk("p8_occ_end", 32'(p8_occ), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
